// File: rtl/tx_resp_arbiter_pkg.sv
// Shared definitions for the Tx response arbiter: FSM encoding, requester IDs, counter sizing.
package sys_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_RD  = 1'b1
    } src_e;

    // Busy-wait counter must be able to hold BUSY_TO itself.
    function automatic int to_cnt_w(input int busy_to);
        return $clog2(busy_to + 1);
    endfunction

endpackage

// File: rtl/tx_resp_arbiter_if.sv
// Response-source inputs, UART handshake and status outputs of the Tx response arbiter.
interface tx_resp_arbiter_if #(
    parameter int width = 8
);
    logic [2*width-1:0] ALU_out;
    logic               ALU_out_valid;
    logic [width-1:0]   RdData;
    logic               Rd_valid;
    logic               Busy;
    logic               Clr_err;
    logic [width-1:0]   Tx_Data;
    logic               Tx_valid;
    logic               Pend_alu;
    logic               Pend_rd;
    logic               Overrun;
    logic               Timeout_err;

    modport master (
        output ALU_out, ALU_out_valid, RdData, Rd_valid, Busy, Clr_err,
        input  Tx_Data, Tx_valid, Pend_alu, Pend_rd, Overrun, Timeout_err
    );

    modport slave (
        input  ALU_out, ALU_out_valid, RdData, Rd_valid, Busy, Clr_err,
        output Tx_Data, Tx_valid, Pend_alu, Pend_rd, Overrun, Timeout_err
    );
endinterface

// File: rtl/tx_resp_arbiter_hold_buf.sv
// One-entry holding buffer for a response source; a load while full (and not released) is dropped.
module resp_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         release_i,
    output logic [W-1:0] data_o,
    output logic         pend_o,
    output logic         ovr_o
);
    logic         pend_q, pend_d;
    logic [W-1:0] data_q, data_d;
    logic         accept;

    // A slot freed this cycle can take the new word immediately.
    assign accept = load_i && (!pend_q || release_i);
    assign ovr_o  = load_i && pend_q && !release_i;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        if (release_i) pend_d = 1'b0;
        if (accept) begin
            pend_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= 1'b0;
        else         pend_q <= pend_d;
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;
    assign pend_o = pend_q;
endmodule

// File: rtl/tx_resp_arbiter.sv
// Arbitrates ALU results (two bytes) and RegFile reads (one byte) onto the UART Tx byte path.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise ALU has fixed priority.
module tx_resp_arbiter
    import sys_pkg::*;
#(
    parameter int width   = 8,
    parameter int BUSY_TO = 255
) (
    input  logic             CLK,
    input  logic             Reset,
    tx_resp_arbiter_if.slave bus
);
    localparam int            CW      = to_cnt_w(BUSY_TO);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TO - 1);

    arb_state_e         state_q, state_d;
    src_e               src_q, src_d;
    logic               idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*width-1:0] shadow_q, shadow_d;
    logic               tx_valid_q, tx_valid_d;
    logic [width-1:0]   tx_data_q, tx_data_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;
    logic               tmo_evt;
    logic               alu_pend, rd_pend, alu_ovr, rd_ovr;
    logic               rel_alu, rel_rd, alu_first;
    logic [2*width-1:0] alu_data;
    logic [width-1:0]   rd_data;

    resp_hold_buf #(.W(2*width)) u_alu_buf (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .load_i    (bus.ALU_out_valid),
        .data_i    (bus.ALU_out),
        .release_i (rel_alu),
        .data_o    (alu_data),
        .pend_o    (alu_pend),
        .ovr_o     (alu_ovr)
    );

    resp_hold_buf #(.W(width)) u_rd_buf (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .load_i    (bus.Rd_valid),
        .data_i    (bus.RdData),
        .release_i (rel_rd),
        .data_o    (rd_data),
        .pend_o    (rd_pend),
        .ovr_o     (rd_ovr)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the source served last; starts at RD so ALU wins the first tie.
    src_e last_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)       last_q <= SRC_RD;
        else if (rel_alu) last_q <= SRC_ALU;
        else if (rel_rd)  last_q <= SRC_RD;
    end

    assign alu_first = (last_q == SRC_RD);
`else
    assign alu_first = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_evt    = 1'b0;
        rel_alu    = 1'b0;
        rel_rd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (alu_pend && (!rd_pend || alu_first)) begin
                    rel_alu  = 1'b1;
                    src_d    = SRC_ALU;
                    shadow_d = alu_data;
                    idx_d    = 1'b0;
                    state_d  = SEND;
                end else if (rd_pend) begin
                    rel_rd   = 1'b1;
                    src_d    = SRC_RD;
                    shadow_d = {{width{1'b0}}, rd_data};
                    idx_d    = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_valid_d = 1'b1;
                tx_data_d  = idx_q ? shadow_q[2*width-1:width] : shadow_q[width-1:0];
                cnt_d      = '0;
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.Busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // Give up on the whole response, including an unsent high byte.
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.Busy) begin
                    if (src_q == SRC_ALU && !idx_q) begin
                        idx_d   = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error event overrides a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        tmo_d = tmo_q;
        if (bus.Clr_err) begin
            ovr_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (alu_ovr || rd_ovr) ovr_d = 1'b1;
        if (tmo_evt)           tmo_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            src_q      <= SRC_ALU;
            idx_q      <= 1'b0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
        end
    end

    always_ff @(posedge CLK) begin
        shadow_q <= shadow_d;
    end

    assign bus.Tx_valid    = tx_valid_q;
    assign bus.Tx_Data     = tx_data_q;
    assign bus.Pend_alu    = alu_pend;
    assign bus.Pend_rd     = rd_pend;
    assign bus.Overrun     = ovr_q;
    assign bus.Timeout_err = tmo_q;
endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed self-checking bench for tx_resp_arbiter with a simple UART Busy responder.
module tb_tx_resp_arbiter;
    localparam int W       = 8;
    localparam int BUSY_TO = 255;

    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    bit   uart_en = 1'b1;

    tx_resp_arbiter_if #(.width(W)) bus ();

    tx_resp_arbiter #(.width(W), .BUSY_TO(BUSY_TO)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // UART model: Busy rises 2 cycles after Tx_valid and falls 10 cycles later.
    initial begin
        bus.Busy = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (uart_en && bus.Tx_valid === 1'b1) begin
                repeat (2) @(posedge CLK);
                #1 bus.Busy = 1'b1;
                repeat (10) @(posedge CLK);
                #1 bus.Busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic pulse_rd(input logic [W-1:0] d);
        bus.RdData = d; bus.Rd_valid = 1'b1;
        step();
        bus.Rd_valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [2*W-1:0] d);
        bus.ALU_out = d; bus.ALU_out_valid = 1'b1;
        step();
        bus.ALU_out_valid = 1'b0;
    endtask

    task automatic pulse_both(input logic [2*W-1:0] a, input logic [W-1:0] r);
        bus.ALU_out = a; bus.ALU_out_valid = 1'b1;
        bus.RdData = r;  bus.Rd_valid = 1'b1;
        step();
        bus.ALU_out_valid = 1'b0; bus.Rd_valid = 1'b0;
    endtask

    // Steps until a Tx_valid pulse; n = cycles waited, -1 if none within the budget.
    task automatic get_byte(output logic [W-1:0] d, output int n);
        n = 0; d = '0;
        while (n < 60) begin
            step(); n++;
            if (bus.Tx_valid === 1'b1) begin
                d = bus.Tx_Data;
                return;
            end
        end
        n = -1;
    endtask

    task automatic quiet(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.Tx_valid !== 1'b0) cnt++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.ALU_out = '0; bus.ALU_out_valid = 1'b0;
        bus.RdData = '0;  bus.Rd_valid = 1'b0; bus.Clr_err = 1'b0;
        step(); step();
        checks++;
        if ({bus.Tx_valid, bus.Tx_Data, bus.Pend_alu, bus.Pend_rd, bus.Overrun, bus.Timeout_err} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h pa=%b pr=%b ov=%b to=%b, required all 0",
                     bus.Tx_valid, bus.Tx_Data, bus.Pend_alu, bus.Pend_rd, bus.Overrun, bus.Timeout_err);
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_rd_single();
        logic [W-1:0] d; int n; int c;
        pulse_rd(8'hA5);
        checks++;
        if (bus.Pend_rd !== 1'b1) begin errors++; $display("FAIL rd_pend_set: got %b required 1", bus.Pend_rd); end
        get_byte(d, n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL rd_latency: got %0d extra cycles required 2", n); end
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h required a5", d); end
        checks++;
        if (bus.Pend_rd !== 1'b0) begin errors++; $display("FAIL rd_pend_clr: got %b required 0", bus.Pend_rd); end
        quiet(14, c);
        checks++;
        if (c != 0) begin errors++; $display("FAIL rd_extra_tx: got %0d pulses required 0", c); end
    endtask

    task automatic test_alu_two_bytes();
        logic [W-1:0] d; int n; int c;
        pulse_alu(16'h12C3);
        checks++;
        if (bus.Pend_alu !== 1'b1) begin errors++; $display("FAIL alu_pend_set: got %b required 1", bus.Pend_alu); end
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'hC3) begin errors++; $display("FAIL alu_byte0: got n=%0d d=%h required n=2 d=c3", n, d); end
        get_byte(d, n);
        checks++;
        if (n != 14 || d !== 8'h12) begin errors++; $display("FAIL alu_byte1: got n=%0d d=%h required n=14 d=12", n, d); end
        quiet(14, c);
        checks++;
        if (c != 0) begin errors++; $display("FAIL alu_extra_tx: got %0d pulses required 0", c); end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] d; int n; int c;
        logic [2*W-1:0] a;
        logic [W-1:0] r;
        logic [W-1:0] exp_b [4];
        for (int k = 0; k < 3; k++) begin
            a = 16'hA0B0 + 16'(k * 257);
            r = 8'hC0 + 8'(k);
            pulse_both(a, r);
            get_byte(d, n);
            checks++;
            if (n != 2 || d !== a[7:0]) begin errors++; $display("FAIL sim_r%0d_lo: got n=%0d d=%h required n=2 d=%h", k, n, d, a[7:0]); end
            get_byte(d, n);
            checks++;
            if (n != 14 || d !== a[15:8]) begin errors++; $display("FAIL sim_r%0d_hi: got n=%0d d=%h required n=14 d=%h", k, n, d, a[15:8]); end
            get_byte(d, n);
            checks++;
            if (n != 15 || d !== r) begin errors++; $display("FAIL sim_r%0d_rd: got n=%0d d=%h required n=15 d=%h", k, n, d, r); end
            quiet(14, c);
        end
        // New ALU request arrives while Rd is still waiting behind the current ALU response.
        pulse_both(16'h0201, 8'hD1);
`ifdef ARB_ROUND_ROBIN_EN
        exp_b = '{8'h01, 8'h02, 8'hD1, 8'h03};
`else
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif
        get_byte(d, n);
        checks++;
        if (n < 0 || d !== exp_b[0]) begin errors++; $display("FAIL arb_b0: got n=%0d d=%h required %h", n, d, exp_b[0]); end
        pulse_alu(16'h0403);
        for (int i = 1; i < 4; i++) begin
            get_byte(d, n);
            checks++;
            if (n < 0 || d !== exp_b[i]) begin errors++; $display("FAIL arb_b%0d: got n=%0d d=%h required %h", i, n, d, exp_b[i]); end
        end
        get_byte(d, n);
        quiet(14, c);
    endtask

    task automatic test_overrun();
        logic [W-1:0] d; int n; int c;
        pulse_alu(16'h5566);
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'h66) begin errors++; $display("FAIL ovr_alu_lo: got n=%0d d=%h required n=2 d=66", n, d); end
        step(); step(); step();
        pulse_rd(8'h11);
        checks++;
        if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_load: got %b required 0", bus.Overrun); end
        bus.RdData = 8'h22; bus.Rd_valid = 1'b1; bus.Clr_err = 1'b1;
        step();
        bus.Rd_valid = 1'b0; bus.Clr_err = 1'b0;
        checks++;
        if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_beats_clr: got %b required 1", bus.Overrun); end
        pulse_rd(8'h33);
        checks++;
        if (bus.Overrun !== 1'b1 || bus.Pend_rd !== 1'b1) begin
            errors++; $display("FAIL ovr_held: got ov=%b pr=%b required 1 1", bus.Overrun, bus.Pend_rd);
        end
        get_byte(d, n);
        checks++;
        if (n < 0 || d !== 8'h55) begin errors++; $display("FAIL ovr_alu_hi: got n=%0d d=%h required 55", n, d); end
        get_byte(d, n);
        checks++;
        if (n < 0 || d !== 8'h11) begin errors++; $display("FAIL ovr_kept_data: got n=%0d d=%h required 11", n, d); end
        quiet(14, c);
        checks++;
        if (c != 0) begin errors++; $display("FAIL ovr_dropped_sent: got %0d pulses required 0", c); end
        bus.Clr_err = 1'b1;
        step();
        bus.Clr_err = 1'b0;
        checks++;
        if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b required 0", bus.Overrun); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d; int n; int c;
        pulse_rd(8'h31);
        pulse_rd(8'h42);
        checks++;
        if (bus.Overrun !== 1'b0 || bus.Pend_rd !== 1'b1) begin
            errors++; $display("FAIL b2b_release_load: got ov=%b pr=%b required 0 1", bus.Overrun, bus.Pend_rd);
        end
        get_byte(d, n);
        checks++;
        if (n != 1 || d !== 8'h31) begin errors++; $display("FAIL b2b_first: got n=%0d d=%h required n=1 d=31", n, d); end
        get_byte(d, n);
        checks++;
        if (n != 15 || d !== 8'h42) begin errors++; $display("FAIL b2b_second: got n=%0d d=%h required n=15 d=42", n, d); end
        quiet(14, c);
    endtask

    task automatic test_timeout();
        logic [W-1:0] d; int n; int c;
        uart_en = 1'b0;
        pulse_alu(16'h7788);
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'h88) begin errors++; $display("FAIL to_lo: got n=%0d d=%h required n=2 d=88", n, d); end
        quiet(BUSY_TO - 1, c);
        checks++;
        if (bus.Timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", bus.Timeout_err); end
        step();
        checks++;
        if (bus.Timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", bus.Timeout_err); end
        quiet(20, n);
        checks++;
        if (c + n != 0 || bus.Pend_alu !== 1'b0) begin
            errors++; $display("FAIL to_hi_dropped: got %0d pulses pa=%b required 0 0", c + n, bus.Pend_alu);
        end
        uart_en = 1'b1;
        pulse_rd(8'h99);
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'h99) begin errors++; $display("FAIL to_next_req: got n=%0d d=%h required n=2 d=99", n, d); end
        bus.Clr_err = 1'b1;
        step();
        bus.Clr_err = 1'b0;
        checks++;
        if (bus.Timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b required 0", bus.Timeout_err); end
        quiet(14, c);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d; int n; int c;
        pulse_alu(16'hBEEF);
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'hEF) begin errors++; $display("FAIL rst_lo: got n=%0d d=%h required n=2 d=ef", n, d); end
        step(); step(); step();
        pulse_rd(8'h44);
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.Tx_valid, bus.Tx_Data, bus.Pend_alu, bus.Pend_rd, bus.Overrun, bus.Timeout_err} !== 13'h0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%h pa=%b pr=%b ov=%b to=%b, required all 0",
                     bus.Tx_valid, bus.Tx_Data, bus.Pend_alu, bus.Pend_rd, bus.Overrun, bus.Timeout_err);
        end
        step(); step();
        Reset = 1'b1;
        quiet(30, c);
        checks++;
        if (c != 0) begin errors++; $display("FAIL rst_no_tx: got %0d pulses required 0", c); end
        pulse_rd(8'h5A);
        get_byte(d, n);
        checks++;
        if (n != 2 || d !== 8'h5A) begin errors++; $display("FAIL rst_next_req: got n=%0d d=%h required n=2 d=5a", n, d); end
        quiet(14, c);
    endtask

    initial begin
        test_reset();
        test_rd_single();
        test_alu_two_bytes();
        test_simultaneous();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
